// File: rtl/mips_debug_sequencer_if.sv
// rtl/mips_debug_sequencer_if.sv - debug read-back bus and frame output stream of the debug sequencer
interface mips_debug_sequencer_if #(
  parameter int NB_FRAME = 32
);
  logic [4:0]          o_reg_addr;
  logic                o_mem_rd_en;
  logic                o_instr_rd_en;
  logic [NB_FRAME-1:0] i_reg_data;
  logic [NB_FRAME-1:0] i_pc;
  logic [NB_FRAME-1:0] i_mem_data;
  logic [NB_FRAME-1:0] i_instr_data;
  logic [NB_FRAME-1:0] o_frame;
  logic                o_frame_valid;
  logic                o_eod;
  logic                o_busy;

  modport master (
    output o_reg_addr, o_mem_rd_en, o_instr_rd_en,
    output o_frame, o_frame_valid, o_eod, o_busy,
    input  i_reg_data, i_pc, i_mem_data, i_instr_data
  );

  modport slave (
    input  o_reg_addr, o_mem_rd_en, o_instr_rd_en,
    input  o_frame, o_frame_valid, o_eod, o_busy,
    output i_reg_data, i_pc, i_mem_data, i_instr_data
  );
endinterface

// File: rtl/mips_debug_sequencer.sv
// rtl/mips_debug_sequencer.sv - serializes a selected pipeline latch, register, memory word or PC into debug frames
// Optional latch snapshot at acceptance enabled by defining MIPS_DEBUG_SNAPSHOT_EN.
module mips_debug_sequencer #(
  parameter int NB_FRAME = 32,
  parameter int NB_LATCH = 96
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [5:0]          i_request_select,
  input  logic [NB_LATCH-1:0] i_latch_fetch_data,
  input  logic [NB_LATCH-1:0] i_latch_fetch_ctrl,
  input  logic [NB_LATCH-1:0] i_latch_deco_data,
  input  logic [NB_LATCH-1:0] i_latch_deco_ctrl,
  input  logic [NB_LATCH-1:0] i_latch_exec_data,
  input  logic [NB_LATCH-1:0] i_latch_exec_ctrl,
  input  logic [NB_LATCH-1:0] i_latch_mem_data,
  input  logic [NB_LATCH-1:0] i_latch_mem_ctrl,
  mips_debug_sequencer_if.master dbg
);
  localparam logic [5:0] SEL_IDLE  = 6'h3F;
  localparam logic [5:0] SEL_MEM   = 6'h20;
  localparam logic [5:0] SEL_INSTR = 6'h21;
  localparam logic [5:0] SEL_PC    = 6'h22;

  typedef enum logic [1:0] {IDLE, WAIT, SEND, EOD} state_t;

  state_t              state_q, state_d;
  logic [1:0]          count_q, count_d;
  logic [5:0]          src_q, src_d;
  logic                arm_q, arm_d;
  logic [NB_FRAME-1:0] frame_q, frame_d;
  logic                valid_q, valid_d;
  logic                eod_q, eod_d;
  logic [4:0]          reg_addr;
  logic                mem_rd, instr_rd;
  logic                accept;
  logic [5:0]          cur_sel;
  logic [NB_LATCH-1:0] latch_live, latch_src;

  function automatic logic is_reg(input logic [5:0] sel);
    return ~sel[5];
  endfunction

  function automatic logic is_latch(input logic [5:0] sel);
    return (sel >= 6'h24) && (sel <= 6'h2B);
  endfunction

  function automatic logic [NB_FRAME-1:0] word_of(input logic [NB_LATCH-1:0] grp, input logic [1:0] idx);
    case (idx)
      2'd0:    return grp[NB_LATCH-1 -: NB_FRAME];
      2'd1:    return grp[NB_LATCH-NB_FRAME-1 -: NB_FRAME];
      default: return grp[NB_FRAME-1:0];
    endcase
  endfunction

  // In IDLE the incoming select picks the group; afterwards the accepted source is held.
  assign cur_sel = (state_q == IDLE) ? i_request_select : src_q;
  assign accept  = (state_q == IDLE) && arm_q && (i_request_select != SEL_IDLE) && !i_reset;

  always_comb begin
    latch_live = '0;
    case (cur_sel)
      6'h24:   latch_live = i_latch_fetch_data;
      6'h25:   latch_live = i_latch_fetch_ctrl;
      6'h26:   latch_live = i_latch_deco_data;
      6'h27:   latch_live = i_latch_deco_ctrl;
      6'h28:   latch_live = i_latch_exec_data;
      6'h29:   latch_live = i_latch_exec_ctrl;
      6'h2A:   latch_live = i_latch_mem_data;
      6'h2B:   latch_live = i_latch_mem_ctrl;
      default: latch_live = '0;
    endcase
  end

`ifdef MIPS_DEBUG_SNAPSHOT_EN
  logic [NB_LATCH-1:0] shadow_q;

  always_ff @(posedge i_clock) begin
    if (i_reset)
      shadow_q <= '0;
    else if (accept)
      shadow_q <= latch_live;
  end

  assign latch_src = (state_q == IDLE) ? latch_live : shadow_q;
`else
  assign latch_src = latch_live;
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    src_d    = src_q;
    frame_d  = '0;
    valid_d  = 1'b0;
    eod_d    = 1'b0;
    reg_addr = '0;
    mem_rd   = 1'b0;
    instr_rd = 1'b0;
    arm_d    = (i_request_select == SEL_IDLE) ? 1'b1 : arm_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          arm_d = 1'b0;
          src_d = i_request_select;
          count_d = 2'd0;
          if (is_latch(i_request_select)) begin
            state_d = SEND;
            frame_d = word_of(latch_src, 2'd0);
            valid_d = 1'b1;
          end else if (i_request_select == SEL_PC) begin
            state_d = SEND;
            frame_d = dbg.i_pc;
            valid_d = 1'b1;
          end else if (is_reg(i_request_select)) begin
            state_d  = WAIT;
            reg_addr = i_request_select[4:0];
          end else if (i_request_select == SEL_MEM) begin
            state_d = WAIT;
            mem_rd  = 1'b1;
          end else if (i_request_select == SEL_INSTR) begin
            state_d  = WAIT;
            instr_rd = 1'b1;
          end else begin
            state_d = EOD;
            eod_d   = 1'b1;
          end
        end
      end
      WAIT: begin
        state_d = SEND;
        count_d = 2'd0;
        valid_d = 1'b1;
        if (is_reg(src_q))
          frame_d = dbg.i_reg_data;
        else if (src_q == SEL_MEM)
          frame_d = dbg.i_mem_data;
        else
          frame_d = dbg.i_instr_data;
      end
      SEND: begin
        if (is_latch(src_q) && (count_q != 2'd2)) begin
          count_d = count_q + 2'd1;
          frame_d = word_of(latch_src, count_q + 2'd1);
          valid_d = 1'b1;
        end else begin
          state_d = EOD;
          count_d = 2'd0;
          eod_d   = 1'b1;
        end
      end
      EOD: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      count_q <= 2'd0;
      src_q   <= SEL_IDLE;
      arm_q   <= 1'b1;
      frame_q <= '0;
      valid_q <= 1'b0;
      eod_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      src_q   <= src_d;
      arm_q   <= arm_d;
      frame_q <= frame_d;
      valid_q <= valid_d;
      eod_q   <= eod_d;
    end
  end

  assign dbg.o_reg_addr    = reg_addr;
  assign dbg.o_mem_rd_en   = mem_rd;
  assign dbg.o_instr_rd_en = instr_rd;
  assign dbg.o_frame       = frame_q;
  assign dbg.o_frame_valid = valid_q;
  assign dbg.o_eod         = eod_q;
  assign dbg.o_busy        = (state_q != IDLE);
endmodule

// File: tb/tb_mips_debug_sequencer.sv
// tb/tb_mips_debug_sequencer.sv - vector table and corner sequences for mips_debug_sequencer
module tb_mips_debug_sequencer;
  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  sel;
  logic [95:0] l_fd, l_fc, l_dd, l_dc, l_ed, l_ec, l_md, l_mc;
  int          total = 0;
  int          bad = 0;

  mips_debug_sequencer_if #(.NB_FRAME(32)) dbg ();

  mips_debug_sequencer #(.NB_FRAME(32), .NB_LATCH(96)) dut (
    .i_clock            (clock),
    .i_reset            (reset),
    .i_request_select   (sel),
    .i_latch_fetch_data (l_fd),
    .i_latch_fetch_ctrl (l_fc),
    .i_latch_deco_data  (l_dd),
    .i_latch_deco_ctrl  (l_dc),
    .i_latch_exec_data  (l_ed),
    .i_latch_exec_ctrl  (l_ec),
    .i_latch_mem_data   (l_md),
    .i_latch_mem_ctrl   (l_mc),
    .dbg                (dbg)
  );

  always #5 clock = ~clock;

  // Register file and memories answer one cycle after the address/strobe.
  function automatic logic [31:0] reg_val(input logic [4:0] a);
    return (a == 5'd5) ? 32'hDEADBEEF : (32'hDEAD0000 | {27'd0, a});
  endfunction

  assign dbg.i_pc = 32'h0040_0100;
  always @(posedge clock) begin
    dbg.i_reg_data   <= reg_val(dbg.o_reg_addr);
    dbg.i_mem_data   <= dbg.o_mem_rd_en   ? 32'h1234_5678 : 32'h0;
    dbg.i_instr_data <= dbg.o_instr_rd_en ? 32'hCAFE_F00D : 32'h0;
  end

  typedef struct {
    logic [5:0]  sel;
    int          lat;
    int          nw;
    logic [31:0] w0, w1, w2;
  } vec_t;

  vec_t vecs [13];

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " frame"}, dbg.o_frame, 32'h0);
    chk({tag, " valid"}, {31'd0, dbg.o_frame_valid}, 32'd0);
    chk({tag, " eod"}, {31'd0, dbg.o_eod}, 32'd0);
    chk({tag, " busy"}, {31'd0, dbg.o_busy}, 32'd0);
    chk({tag, " reg_addr"}, {27'd0, dbg.o_reg_addr}, 32'd0);
    chk({tag, " rd_en"}, {30'd0, dbg.o_mem_rd_en, dbg.o_instr_rd_en}, 32'd0);
  endtask

  task automatic run_vec(input int id);
    vec_t        v;
    logic [31:0] ef;
    logic        ev;
    v = vecs[id];
    sel = 6'h3F;
    tick;
    tick;
    sel = v.sel;
    #1;
    chk($sformatf("v%0d reg_addr", id), {27'd0, dbg.o_reg_addr},
        (v.sel < 6'h20) ? {27'd0, v.sel[4:0]} : 32'd0);
    chk($sformatf("v%0d mem_rd", id), {31'd0, dbg.o_mem_rd_en}, {31'd0, v.sel == 6'h20});
    chk($sformatf("v%0d instr_rd", id), {31'd0, dbg.o_instr_rd_en}, {31'd0, v.sel == 6'h21});
    for (int k = 1; k <= 7; k++) begin
      tick;
      ev = (k >= v.lat) && (k < v.lat + v.nw);
      ef = !ev ? 32'h0 : (k == v.lat) ? v.w0 : (k == v.lat + 1) ? v.w1 : v.w2;
      chk($sformatf("v%0d T+%0d valid", id, k), {31'd0, dbg.o_frame_valid}, {31'd0, ev});
      chk($sformatf("v%0d T+%0d frame", id, k), dbg.o_frame, ef);
      chk($sformatf("v%0d T+%0d eod", id, k), {31'd0, dbg.o_eod}, {31'd0, k == v.lat + v.nw});
      chk($sformatf("v%0d T+%0d busy", id, k), {31'd0, dbg.o_busy}, {31'd0, k <= v.lat + v.nw});
    end
    sel = 6'h3F;
  endtask

  initial begin
    int nv, ne;
    vecs[0]  = '{6'h24, 1, 3, 32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003};
    vecs[1]  = '{6'h25, 1, 3, 32'h11110001, 32'h11110002, 32'h11110003};
    vecs[2]  = '{6'h28, 1, 3, 32'h44440001, 32'h44440002, 32'h44440003};
    vecs[3]  = '{6'h2B, 1, 3, 32'h77770001, 32'h77770002, 32'h77770003};
    vecs[4]  = '{6'h05, 2, 1, 32'hDEADBEEF, 32'h0, 32'h0};
    vecs[5]  = '{6'h00, 2, 1, 32'hDEAD0000, 32'h0, 32'h0};
    vecs[6]  = '{6'h1F, 2, 1, 32'hDEAD001F, 32'h0, 32'h0};
    vecs[7]  = '{6'h20, 2, 1, 32'h12345678, 32'h0, 32'h0};
    vecs[8]  = '{6'h21, 2, 1, 32'hCAFEF00D, 32'h0, 32'h0};
    vecs[9]  = '{6'h22, 1, 1, 32'h00400100, 32'h0, 32'h0};
    vecs[10] = '{6'h3A, 1, 0, 32'h0, 32'h0, 32'h0};
    vecs[11] = '{6'h23, 1, 0, 32'h0, 32'h0, 32'h0};
    vecs[12] = '{6'h2C, 1, 0, 32'h0, 32'h0, 32'h0};

    l_fd = 96'hAAAA0001_BBBB0002_CCCC0003;
    l_fc = 96'h11110001_11110002_11110003;
    l_dd = 96'h22220001_22220002_22220003;
    l_dc = 96'h33330001_33330002_33330003;
    l_ed = 96'h44440001_44440002_44440003;
    l_ec = 96'h55550001_55550002_55550003;
    l_md = 96'h66660001_66660002_66660003;
    l_mc = 96'h77770001_77770002_77770003;
    sel   = 6'h3F;
    reset = 1'b1;
    tick;
    tick;
    chk_idle("reset");
    reset = 1'b0;
    tick;

    for (int i = 0; i < 13; i++)
      run_vec(i);

    // Held PC select triggers once; re-arming via idle code allows a second transfer.
    tick;
    tick;
    sel = 6'h22;
    nv = 0;
    ne = 0;
    for (int k = 0; k < 10; k++) begin
      tick;
      nv += int'(dbg.o_frame_valid);
      ne += int'(dbg.o_eod);
    end
    chk("held pc frames", nv, 1);
    chk("held pc eods", ne, 1);
    sel = 6'h3F;
    tick;
    sel = 6'h22;
    nv = 0;
    ne = 0;
    for (int k = 0; k < 5; k++) begin
      tick;
      nv += int'(dbg.o_frame_valid);
      ne += int'(dbg.o_eod);
    end
    chk("rearm pc frames", nv, 1);
    chk("rearm pc eods", ne, 1);

    // Reset while word1 of mem_data latch is on the output aborts without eod.
    sel = 6'h3F;
    tick;
    tick;
    sel = 6'h2A;
    tick;
    chk("abort word0", dbg.o_frame, 32'h66660001);
    tick;
    chk("abort word1", dbg.o_frame, 32'h66660002);
    reset = 1'b1;
    tick;
    chk_idle("abort");
    sel   = 6'h3F;
    reset = 1'b0;
    ne = 0;
    for (int k = 0; k < 4; k++) begin
      tick;
      ne += int'(dbg.o_eod) + int'(dbg.o_frame_valid);
    end
    chk("abort quiet", ne, 0);

    // Latch changes after acceptance: snapshot keeps originals, live mode follows.
    sel = 6'h3F;
    tick;
    sel = 6'h24;
    tick;
    l_fd = 96'h99990001_88880002_77770003;
    chk("snap word0", dbg.o_frame, 32'hAAAA0001);
    tick;
`ifdef MIPS_DEBUG_SNAPSHOT_EN
    chk("snap word1", dbg.o_frame, 32'hBBBB0002);
    tick;
    chk("snap word2", dbg.o_frame, 32'hCCCC0003);
`else
    chk("live word1", dbg.o_frame, 32'h88880002);
    tick;
    chk("live word2", dbg.o_frame, 32'h77770003);
`endif
    tick;
    chk("snap eod", {31'd0, dbg.o_eod}, 32'd1);
    sel = 6'h3F;
    tick;
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mips_debug_sequencer.md
MIPS_DEBUG_SEQUENCER -- requirements
Module: mips_debug_sequencer

Interface
REQ-001 Parameter NB_FRAME, default 32, width of one debug frame word.
REQ-002 Parameter NB_LATCH, default 96, width of every pipeline latch group; equals 3*NB_FRAME.
REQ-003 i_clock  in  1  clock; i_reset  in  1  reset; i_reset is synchronous, active-high; clock i_clock.
REQ-004 i_request_select  in  6  source select; 6'h3F = idle.
REQ-005 i_latch_fetch_data, i_latch_fetch_ctrl, i_latch_deco_data, i_latch_deco_ctrl, i_latch_exec_data, i_latch_exec_ctrl, i_latch_mem_data, i_latch_mem_ctrl  in  NB_LATCH each  pipeline latch groups.
REQ-006 i_reg_data  in  NB_FRAME  register-file debug read data, 1-cycle latency after o_reg_addr.
REQ-007 i_pc  in  NB_FRAME  current PC.
REQ-008 i_mem_data / i_instr_data  in  NB_FRAME each  data/instruction memory read data, 1-cycle latency after rd_en.
REQ-009 o_reg_addr  out  5  register-file debug read address.
REQ-010 o_mem_rd_en / o_instr_rd_en  out  1 each  single-cycle memory read strobes.
REQ-011 o_frame  out  NB_FRAME  registered serialized word; o_frame_valid  out  1  word valid.
REQ-012 o_eod  out  1  single-cycle end-of-data pulse; o_busy  out  1  high in any state other than IDLE.

Function
REQ-013 Select decode SHALL be: 0x00-0x1F register n; 0x20 data mem; 0x21 instr mem; 0x22 PC; 0x24-0x2B latch groups in REQ-005 order; 0x3F idle; all other codes invalid.
REQ-014 FSM states SHALL be IDLE, WAIT, SEND, EOD.
REQ-015 Arm flag SHALL be set when select equals 0x3F; a request is accepted only in IDLE with arm set and select != 0x3F; acceptance clears arm, so a held select never retriggers.
REQ-016 IDLE -> SEND on an accepted latch or PC request: word buffer loaded, word counter = 0.
REQ-017 IDLE -> WAIT on an accepted register/memory request: o_reg_addr = select[4:0] or the matching rd_en pulsed in the acceptance cycle.
REQ-018 WAIT lasts exactly one cycle, captures the read data into word 0, then goes to SEND.
REQ-019 IDLE -> EOD on an accepted invalid code: zero words sent.
REQ-020 In SEND, o_frame_valid = 1, one word per cycle, MSB-first: word0 = [95:64], word1 = [63:32], word2 = [31:0]; latches send 3 words, register/memory/PC send 1.
REQ-021 First valid word SHALL appear the cycle after acceptance for latch/PC sources and two cycles after for register/memory sources.
REQ-022 After the last word -> EOD: o_eod = 1 for one cycle, o_frame = 0, o_frame_valid = 0; then -> IDLE.
REQ-023 Select changes in WAIT/SEND/EOD SHALL be ignored; the word counter is 2 bits, never exceeds 2, and never wraps.
REQ-024 Outside SEND, o_frame = 0 and o_frame_valid = 0.

Reset
REQ-025 i_reset SHALL force IDLE, arm = 1, counter = 0, and all outputs to 0, in any state, aborting a transfer without emitting o_eod.

Configuration
REQ-026 Macro MIPS_DEBUG_SNAPSHOT_EN defined: the selected latch group is copied into an NB_LATCH shadow register at acceptance, and all words come from that copy.
REQ-027 Macro undefined: no shadow register; each SEND cycle reads its word live from the selected latch input; register/memory/PC behaviour is unchanged.

Verification
REQ-028 Select 0x24 with fetch_data = 96'hAAAA0001_BBBB0002_CCCC0003 -> frames 32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003 on consecutive cycles starting T+1, o_eod at T+4.
REQ-029 Select 0x05, reg5 = 32'hDEADBEEF -> o_reg_addr = 5 at T, one frame 32'hDEADBEEF at T+2, o_eod at T+3.
REQ-030 Select 0x3A (invalid) -> no valid frames, o_eod at T+1, back in IDLE at T+2.
REQ-031 Select held at 0x22 for 10 cycles -> exactly one PC frame and one o_eod; a second transfer occurs only after 0x3F then 0x22.
REQ-032 i_reset asserted in the cycle word1 of 0x2A is sent -> next cycle all outputs 0, no o_eod, IDLE.
REQ-033 With MIPS_DEBUG_SNAPSHOT_EN, latch input changed after acceptance -> frames equal the original values; without the macro -> frames equal the live values.
